// File: rtl/pipe4_core.sv
// pipe4_core: 4-stage fetch/decode/execute/writeback integer pipeline with forwarding
module pipe4_core #(
  parameter int DATA_W = 8,
  parameter int RA_W = 3,
  parameter int IMM_W = 8,
  parameter int PC_W = 8,
  parameter int CNT_W = 16,
  localparam int INSN_W = 2 + 2 * RA_W + IMM_W
) (
  input  logic              clock,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_insn,
  input  logic              imem_valid,
  output logic [RA_W-1:0]   ctrl_readReg,
  input  logic [DATA_W-1:0] data_readReg,
  output logic              ctrl_writeEnable,
  output logic [RA_W-1:0]   ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic [CNT_W-1:0]  retired
);
  logic [PC_W-1:0] pc;
  logic fd_v, dx_v, xw_v;
  logic [INSN_W-1:0] fd_insn;
  logic [1:0] dx_op;
  logic [RA_W-1:0] fd_rs, dx_rd, xw_rd;
  logic [IMM_W-1:0] dx_imm;
  logic [DATA_W-1:0] dx_a, xw_res, fwd_a, ex_res, imm_x;
  assign fd_rs = fd_insn[IMM_W +: RA_W];
  assign imm_x = DATA_W'($signed(dx_imm));
  assign ex_res = dx_op == 2'b00 ? dx_a + imm_x :
                  dx_op == 2'b01 ? dx_a - imm_x :
                  dx_op == 2'b10 ? dx_a & imm_x : imm_x;
  assign fwd_a = (dx_v && dx_rd == fd_rs && fd_rs != '0) ? ex_res :
                 (xw_v && xw_rd == fd_rs && fd_rs != '0) ? xw_res : data_readReg;
  assign imem_addr = pc;
  assign ctrl_readReg = fd_rs;
  assign ctrl_writeEnable = xw_v && xw_rd != '0;
  assign ctrl_writeReg = xw_rd;
  assign data_writeReg = xw_res;
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= '0;
      fd_v <= 1'b0;
      dx_v <= 1'b0;
      xw_v <= 1'b0;
      fd_insn <= '0;
      dx_op <= '0;
      dx_rd <= '0;
      dx_imm <= '0;
      dx_a <= '0;
      xw_rd <= '0;
      xw_res <= '0;
      retired <= '0;
    end else begin
      fd_v <= imem_valid;
      if (imem_valid) begin
        fd_insn <= imem_insn;
        pc <= pc + 1'b1;
      end
      dx_v <= fd_v;
      dx_op <= fd_insn[INSN_W-1 -: 2];
      dx_rd <= fd_insn[INSN_W-3 -: RA_W];
      dx_imm <= fd_insn[IMM_W-1:0];
      dx_a <= fwd_a;
      xw_v <= dx_v;
      xw_rd <= dx_rd;
      xw_res <= ex_res;
      if (xw_v) retired <= retired + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe4_core.sv
// tb_pipe4_core: scoreboard bench for pipe4_core with directed instruction vectors
module tb_pipe4_core;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] imem_addr;
  logic [15:0] imem_insn = '0;
  logic imem_valid = 1'b0;
  logic [2:0] ctrl_readReg;
  logic [7:0] data_readReg;
  logic ctrl_writeEnable;
  logic [2:0] ctrl_writeReg;
  logic [7:0] data_writeReg;
  logic [15:0] retired;
  typedef struct {logic [2:0] rg; logic [7:0] d; int c;} wr_t;
  wr_t wq[$];
  int rq[$];
  int cyc = 0;
  int r_exp = 0;
  int checks = 0;
  int failures = 0;
  logic [7:0] rf [8];
  pipe4_core dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_insn(imem_insn),
    .imem_valid(imem_valid), .ctrl_readReg(ctrl_readReg), .data_readReg(data_readReg),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .retired(retired)
  );
  always #5 clock = ~clock;
  assign data_readReg = ctrl_readReg == 3'd0 ? 8'd0 : rf[ctrl_readReg];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ctrl_writeEnable === 1'b1) rf[ctrl_writeReg] <= data_writeReg;
  end
  always @(negedge clock) begin
    if (!reset) begin
      if (ctrl_writeEnable === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d got r%0d=%h required none", cyc, ctrl_writeReg, data_writeReg);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (e.rg !== ctrl_writeReg || e.d !== data_writeReg || e.c != cyc) begin
            failures++;
            $display("FAIL write cyc=%0d got r%0d=%h required r%0d=%h at cyc %0d", cyc, ctrl_writeReg, data_writeReg, e.rg, e.d, e.c);
          end
        end
      end else if (wq.size() != 0 && wq[0].c <= cyc) begin
        wr_t e;
        e = wq.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_write cyc=%0d got we=%b required r%0d=%h", cyc, ctrl_writeEnable, e.rg, e.d);
      end
      while (rq.size() != 0 && rq[0] <= cyc) begin
        void'(rq.pop_front());
        r_exp++;
      end
      checks++;
      if (retired !== 16'(r_exp)) begin
        failures++;
        $display("FAIL retired cyc=%0d got %0d required %0d", cyc, retired, r_exp);
      end
    end
  end
  function automatic logic [15:0] mk(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask
  task automatic step(input logic v, input logic [15:0] insn, input bit w, input logic [2:0] rg, input logic [7:0] d);
    reset = 1'b0;
    imem_valid = v;
    imem_insn = insn;
    if (v) rq.push_back(cyc + 4);
    if (w) wq.push_back('{rg, d, cyc + 3});
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset(input int n);
    reset = 1'b1;
    imem_valid = 1'b1;
    imem_insn = mk(2'b11, 3'd1, 3'd0, 8'h55);
    wq.delete();
    rq.delete();
    r_exp = 0;
    repeat (n) begin
      @(posedge clock);
      #1;
      chk("rst_addr", 16'(imem_addr), 16'h0);
      chk("rst_we", 16'(ctrl_writeEnable), 16'h0);
      chk("rst_wreg", 16'(ctrl_writeReg), 16'h0);
      chk("rst_wdata", 16'(data_writeReg), 16'h0);
      chk("rst_rreg", 16'(ctrl_readReg), 16'h0);
      chk("rst_retired", retired, 16'h0);
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    do_reset(2);
    step(1, mk(2'b11, 3'd1, 3'd0, 8'd5), 1, 3'd1, 8'd5);
    step(1, mk(2'b00, 3'd2, 3'd1, 8'd3), 1, 3'd2, 8'd8);
    step(1, mk(2'b01, 3'd3, 3'd2, 8'd1), 1, 3'd3, 8'd7);
    step(1, mk(2'b11, 3'd1, 3'd0, 8'd9), 1, 3'd1, 8'd9);
    step(0, '0, 0, 3'd0, 8'd0);
    step(1, mk(2'b00, 3'd2, 3'd1, 8'd1), 1, 3'd2, 8'd10);
    step(1, mk(2'b11, 3'd1, 3'd0, 8'hFF), 1, 3'd1, 8'hFF);
    step(1, mk(2'b00, 3'd1, 3'd1, 8'd1), 1, 3'd1, 8'h00);
    step(1, mk(2'b01, 3'd2, 3'd0, 8'd1), 1, 3'd2, 8'hFF);
    step(1, mk(2'b11, 3'd1, 3'd0, 8'hAB), 1, 3'd1, 8'hAB);
    step(1, mk(2'b10, 3'd3, 3'd1, 8'h0F), 1, 3'd3, 8'h0B);
    step(1, mk(2'b11, 3'd0, 3'd0, 8'd7), 0, 3'd0, 8'd0);
    step(1, mk(2'b00, 3'd1, 3'd0, 8'd2), 1, 3'd1, 8'd2);
    step(1, mk(2'b11, 3'd4, 3'd0, 8'd5), 1, 3'd4, 8'd5);
    step(1, mk(2'b00, 3'd4, 3'd4, 8'd3), 1, 3'd4, 8'd8);
    step(1, mk(2'b00, 3'd5, 3'd4, 8'd1), 1, 3'd5, 8'd9);
    repeat (4) step(0, '0, 0, 3'd0, 8'd0);
    chk("drain_writes", 16'(wq.size()), 16'h0);
    step(1, mk(2'b11, 3'd0, 3'd0, 8'h11), 0, 3'd0, 8'd0);
    step(1, mk(2'b11, 3'd6, 3'd0, 8'h22), 0, 3'd0, 8'd0);
    step(1, mk(2'b11, 3'd7, 3'd0, 8'h33), 0, 3'd0, 8'd0);
    do_reset(1);
    repeat (3) begin
      step(0, '0, 0, 3'd0, 8'd0);
      chk("flush_we", 16'(ctrl_writeEnable), 16'h0);
      chk("flush_retired", retired, 16'h0);
    end
    chk("pc_start", 16'(imem_addr), 16'h0);
    repeat (255) step(1, mk(2'b11, 3'd0, 3'd0, 8'h00), 0, 3'd0, 8'd0);
    chk("pc_max", 16'(imem_addr), 16'hFF);
    step(1, mk(2'b11, 3'd0, 3'd0, 8'h00), 0, 3'd0, 8'd0);
    chk("pc_wrap", 16'(imem_addr), 16'h0);
    repeat (5) step(0, '0, 0, 3'd0, 8'd0);
    chk("final_writes", 16'(wq.size()), 16'h0);
    chk("final_retires", 16'(rq.size()), 16'h0);
    chk("final_retired", retired, 16'd256);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
